// File: rtl/mul_seq_unit.sv
// mul_seq_unit: multi-cycle unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Fixed latency of WIDTH iterations; done is a one-cycle write strobe for the product.
module mul_seq_unit #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, acc_next, product_q, product_d;
   logic [CW-1:0]      count_q, count_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic [WIDTH:0]     sum;
   // The multiplier rides in the low half of acc and is consumed LSB-first as the product shifts in.
   always_comb begin
      sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_next  = {sum, acc_q[WIDTH-1:1]};
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      count_d   = count_q;
      product_d = product_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = CALC;
            mcand_d = a;
            acc_d   = {{WIDTH{1'b0}}, b};
            count_d = CW'(WIDTH);
            busy_d  = 1'b1;
         end
         CALC: begin
            acc_d   = acc_next;
            count_d = count_q - 1'b1;
            if (count_q == CW'(1)) begin
               state_d   = DONE;
               product_d = acc_next;
               busy_d    = 1'b0;
               done_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end
   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;
endmodule
